// File: rtl/fib_stream_checker.sv
// Checks a sampled stream against the mod-2^W Fibonacci recurrence and reports
// lock, error/restart pulses and saturating term/error counters.
module fib_stream_checker #(
  parameter int W      = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             restart_pulse,
  output logic [CNT_W-1:0] term_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     expected
);

  typedef enum logic [1:0] {SEED0, SEED1, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [3:0]       LOCK    = 4'(LOCK_N);

  state_t           state, state_nx;
  logic [W-1:0]     prev1, prev2, prev1_nx, prev2_nx, expected_nx;
  logic [3:0]       run, run_nx;
  logic             locked_nx, err_pulse_nx, err_sticky_nx, restart_pulse_nx;
  logic [CNT_W-1:0] term_cnt_nx, err_cnt_nx;

  always_comb begin
    state_nx         = state;
    prev1_nx         = prev1;
    prev2_nx         = prev2;
    run_nx           = run;
    locked_nx        = locked;
    err_pulse_nx     = 1'b0;
    restart_pulse_nx = 1'b0;
    err_sticky_nx    = err_sticky;
    term_cnt_nx      = term_cnt;
    err_cnt_nx       = err_cnt;
    if (clr) begin
      state_nx      = SEED0;
      prev1_nx      = '0;
      prev2_nx      = '0;
      run_nx        = '0;
      locked_nx     = 1'b0;
      err_sticky_nx = 1'b0;
      term_cnt_nx   = '0;
      err_cnt_nx    = '0;
    end else if (en) begin
      if (term_cnt != CNT_MAX) term_cnt_nx = term_cnt + 1'b1;
      case (state)
        SEED0: begin
          prev2_nx = din;
          state_nx = SEED1;
        end
        SEED1: begin
          prev1_nx = din;
          state_nx = CHECK;
        end
        default: begin
          if (din == expected) begin
            prev2_nx = prev1;
            prev1_nx = din;
            if (run != LOCK) run_nx = run + 4'd1;
            if (run_nx == LOCK) locked_nx = 1'b1;
          end else if (din == '0) begin
            // a zero where a non-zero term was due means the generator restarted
            restart_pulse_nx = 1'b1;
            locked_nx        = 1'b0;
            run_nx           = '0;
            prev2_nx         = '0;
            state_nx         = SEED1;
          end else begin
            err_pulse_nx  = 1'b1;
            err_sticky_nx = 1'b1;
            if (err_cnt != CNT_MAX) err_cnt_nx = err_cnt + 1'b1;
            locked_nx     = 1'b0;
            run_nx        = '0;
            prev2_nx      = prev1;
            prev1_nx      = din;
          end
        end
      endcase
    end
    // carry dropped on purpose: the generator wraps mod 2^W
    expected_nx = prev1_nx + prev2_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SEED0;
      prev1         <= '0;
      prev2         <= '0;
      run           <= '0;
      locked        <= 1'b0;
      err_pulse     <= 1'b0;
      err_sticky    <= 1'b0;
      restart_pulse <= 1'b0;
      term_cnt      <= '0;
      err_cnt       <= '0;
      expected      <= '0;
    end else begin
      state         <= state_nx;
      prev1         <= prev1_nx;
      prev2         <= prev2_nx;
      run           <= run_nx;
      locked        <= locked_nx;
      err_pulse     <= err_pulse_nx;
      err_sticky    <= err_sticky_nx;
      restart_pulse <= restart_pulse_nx;
      term_cnt      <= term_cnt_nx;
      err_cnt       <= err_cnt_nx;
      expected      <= expected_nx;
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker: a CNT_W=8 and a CNT_W=4 instance share stimulus
// and are compared against an arithmetic model of the checker.
module tb_fib_stream_checker;
  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [3:0] din;

  logic       a_locked, a_err_pulse, a_err_sticky, a_restart_pulse;
  logic [7:0] a_term_cnt, a_err_cnt;
  logic [3:0] a_expected;
  logic       b_locked, b_err_pulse, b_err_sticky, b_restart_pulse;
  logic [3:0] b_term_cnt, b_err_cnt;
  logic [3:0] b_expected;

  fib_stream_checker #(.W(4), .CNT_W(8), .LOCK_N(LOCK_N)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(a_locked), .err_pulse(a_err_pulse), .err_sticky(a_err_sticky),
    .restart_pulse(a_restart_pulse), .term_cnt(a_term_cnt), .err_cnt(a_err_cnt),
    .expected(a_expected));

  fib_stream_checker #(.W(4), .CNT_W(4), .LOCK_N(LOCK_N)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(b_locked), .err_pulse(b_err_pulse), .err_sticky(b_err_sticky),
    .restart_pulse(b_restart_pulse), .term_cnt(b_term_cnt), .err_cnt(b_err_cnt),
    .expected(b_expected));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // model: phase counts seeds taken (2 = checking), p2/p1 are the last two terms
  int phase, p1, p2, run, tc, ec;
  bit lk, ep, es, rp;

  task automatic m_reset();
    phase = 0; p1 = 0; p2 = 0; run = 0; tc = 0; ec = 0;
    lk = 0; ep = 0; es = 0; rp = 0;
  endtask

  function automatic int m_next();
    return (p1 + p2) % 16;
  endfunction

  task automatic m_step(input bit e, input int d, input bit c);
    int x;
    ep = 0; rp = 0;
    if (c) m_reset();
    else if (e) begin
      tc++;
      if (phase == 0) begin
        p2 = d; phase = 1;
      end else if (phase == 1) begin
        p1 = d; phase = 2;
      end else begin
        x = m_next();
        if (d == x) begin
          p2 = p1; p1 = d;
          if (run < LOCK_N) run++;
          if (run == LOCK_N) lk = 1;
        end else if (d == 0) begin
          rp = 1; lk = 0; run = 0; p2 = 0; phase = 1;
        end else begin
          ep = 1; es = 1; ec++; lk = 0; run = 0; p2 = p1; p1 = d;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("a_locked", a_locked, lk);
    cmp("a_err_pulse", a_err_pulse, ep);
    cmp("a_err_sticky", a_err_sticky, es);
    cmp("a_restart_pulse", a_restart_pulse, rp);
    cmp("a_term_cnt", a_term_cnt, tc > 255 ? 255 : tc);
    cmp("a_err_cnt", a_err_cnt, ec > 255 ? 255 : ec);
    cmp("b_locked", b_locked, lk);
    cmp("b_err_pulse", b_err_pulse, ep);
    cmp("b_restart_pulse", b_restart_pulse, rp);
    cmp("b_term_cnt", b_term_cnt, tc > 15 ? 15 : tc);
    cmp("b_err_cnt", b_err_cnt, ec > 15 ? 15 : ec);
    if (phase == 2) begin
      cmp("a_expected", a_expected, m_next());
      cmp("b_expected", b_expected, m_next());
    end
  endtask

  // called just after a rising edge; returns just after the next one
  task automatic apply(input bit e, input int d, input bit c);
    en = e; din = 4'(d); clr = c;
    @(posedge clk);
    m_step(e, d, c);
    #1;
    check_all();
    en = 0; clr = 0;
  endtask

  typedef struct {
    int din;
    bit lk;
    int ex;
    bit chk;
  } vec_t;
  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0, 0, 0, 0};   tbl[1]  = '{1, 0, 1, 1};
    tbl[2]  = '{1, 0, 2, 1};   tbl[3]  = '{2, 0, 3, 1};
    tbl[4]  = '{3, 1, 5, 1};   tbl[5]  = '{5, 1, 8, 1};
    tbl[6]  = '{8, 1, 13, 1};  tbl[7]  = '{13, 1, 5, 1};
    tbl[8]  = '{5, 1, 2, 1};   tbl[9]  = '{2, 1, 7, 1};
    tbl[10] = '{7, 1, 9, 1};   tbl[11] = '{9, 1, 0, 1};
    tbl[12] = '{0, 1, 9, 1};   tbl[13] = '{9, 1, 9, 1};
    tbl[14] = '{9, 1, 2, 1};   tbl[15] = '{2, 1, 11, 1};

    rst = 1; en = 0; clr = 0; din = 0;
    m_reset();
    @(posedge clk); #1;
    check_all();
    cmp("reset_expected", a_expected, 0);
    rst = 0;

    // nominal stream, including wrap 8+13->5 and the legitimate zero
    for (int i = 0; i < 16; i++) begin
      apply(1, tbl[i].din, 0);
      cmp("tbl_locked", a_locked, tbl[i].lk);
      if (tbl[i].chk) cmp("tbl_expected", a_expected, tbl[i].ex);
      cmp("tbl_term_cnt", a_term_cnt, i + 1);
      cmp("tbl_err_cnt", a_err_cnt, 0);
      cmp("tbl_restart", a_restart_pulse, 0);
    end

    // en gating
    apply(0, 0, 1);
    apply(1, 0, 0); apply(1, 1, 0); apply(1, 1, 0); apply(1, 2, 0);
    for (int i = 0; i < 15; i++) apply(0, $urandom_range(15), 0);
    cmp("gate_term_cnt_hold", a_term_cnt, 4);
    apply(1, 3, 0); apply(1, 5, 0);
    cmp("gate_term_cnt", a_term_cnt, 6);
    cmp("gate_err_cnt", a_err_cnt, 0);
    cmp("gate_locked", a_locked, 1);

    // corrupt term then resync; 6+10 wraps to a legitimate 0
    apply(0, 0, 1);
    apply(1, 0, 0); apply(1, 1, 0); apply(1, 1, 0); apply(1, 2, 0);
    apply(1, 4, 0);
    cmp("corrupt_err_pulse", a_err_pulse, 1);
    apply(1, 6, 0);
    cmp("corrupt_pulse_drop", a_err_pulse, 0);
    cmp("corrupt_err_cnt", a_err_cnt, 1);
    cmp("corrupt_sticky", a_err_sticky, 1);
    cmp("corrupt_locked", a_locked, 0);
    apply(1, 10, 0); apply(1, 0, 0);
    cmp("resync_locked", a_locked, 1);
    cmp("resync_zero_not_restart", a_restart_pulse, 0);

    // restart
    apply(0, 0, 1);
    apply(1, 0, 0); apply(1, 1, 0); apply(1, 1, 0); apply(1, 2, 0);
    apply(1, 3, 0); apply(1, 5, 0); apply(1, 8, 0);
    apply(1, 0, 0);
    cmp("restart_pulse", a_restart_pulse, 1);
    cmp("restart_err_pulse", a_err_pulse, 0);
    cmp("restart_locked", a_locked, 0);
    apply(1, 1, 0); apply(1, 1, 0); apply(1, 2, 0);
    cmp("restart_not_yet", a_locked, 0);
    apply(1, 3, 0);
    cmp("restart_relock", a_locked, 1);
    cmp("restart_err_cnt", a_err_cnt, 0);

    // saturation of the narrow instance
    apply(0, 0, 1);
    apply(1, 0, 0); apply(1, 1, 0);
    for (int i = 0; i < 20; i++) apply(1, (m_next() == 15) ? 1 : m_next() + 1, 0);
    cmp("sat_b_term_cnt", b_term_cnt, 15);
    cmp("sat_b_err_cnt", b_err_cnt, 15);
    cmp("sat_a_term_cnt", a_term_cnt, 22);
    cmp("sat_a_err_cnt", a_err_cnt, 20);

    // clr beats en; sample ignored
    apply(1, 5, 1);
    cmp("clr_term_cnt", a_term_cnt, 0);
    cmp("clr_sticky", a_err_sticky, 0);
    apply(1, 3, 0); apply(1, 4, 0);
    cmp("clr_reseed_expected", a_expected, 7);

    // async reset between edges
    apply(1, 7, 0);
    #2 rst = 1;
    #1;
    cmp("arst_term_cnt", a_term_cnt, 0);
    cmp("arst_err_cnt", a_err_cnt, 0);
    cmp("arst_sticky", a_err_sticky, 0);
    cmp("arst_expected", a_expected, 0);
    m_reset();
    #1 rst = 0;
    @(posedge clk); #1;
    apply(1, 2, 0); apply(1, 3, 0);
    cmp("arst_reseed_expected", a_expected, 5);

    // random stream: mostly valid continuations, some zeros, garbage, gaps, clears
    for (int i = 0; i < 800; i++) begin
      int r, d;
      r = $urandom_range(99);
      if (r < 65) d = m_next();
      else if (r < 75) d = 0;
      else d = $urandom_range(15);
      apply($urandom_range(4) != 0, d, $urandom_range(59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Downstream consumer of the 4-bit Fibonacci generator's `out` stream.
- Samples the stream on cycles where `en` is high and checks every term against the mod-2^W Fibonacci recurrence (term = previous + one-before, modulo 2^W).
- Reports lock status, per-term error pulses, restart detection and saturating statistics to the bench or a status register bank.
- Lets the generator be checked in-system, not only by waveform inspection.

Parameters:
- W, 4, data width of the sampled term; must match the generator output width.
- CNT_W, 8, width of the term and error counters.
- LOCK_N, 3, number of consecutive matching terms needed to assert `locked`; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  sample qualifier; `din` is consumed only on cycles where `en`=1.
- din  input  W  term from the generator.
- clr  input  1  synchronous clear of counters, flags and state; same effect as reset but synchronous.
- locked  output  1  high after LOCK_N consecutive matches.
- err_pulse  output  1  one-cycle pulse on a mismatched term.
- err_sticky  output  1  set on the first mismatch, held until rst or clr.
- restart_pulse  output  1  one-cycle pulse when a restart (0 in place of expected) is detected.
- term_cnt  output  CNT_W  accepted samples since rst/clr, saturating.
- err_cnt  output  CNT_W  mismatches since rst/clr, saturating.
- expected  output  W  next predicted term; valid only in state CHECK.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=SEED0, prev1=prev2=0, match_run=0.
  - All outputs 0.
- clr=1 at a clock edge:
  - Same values as reset, applied at that edge.
  - Takes priority over en in the same cycle.
- en=0: no state or counter change. `err_pulse` and `restart_pulse` return to 0.
- All outputs are registered and reflect a sample one cycle after the edge where en=1 captured it.
- `expected` = (prev1 + prev2) mod 2^W, registered. The carry is discarded; wrap-around is legal (8 + 13 -> 5).
- Every accepted sample: term_cnt++. Saturates at 2^CNT_W-1, no wrap.
- State machine:
  - SEED0, en=1: prev2 <= din; go to SEED1.
  - SEED1, en=1: prev1 <= din; go to CHECK. Any two values are accepted as seeds.
  - CHECK, en=1, din == expected (match):
    - prev2 <= prev1, prev1 <= din.
    - match_run++ (saturates at LOCK_N).
    - locked <= 1 when match_run reaches LOCK_N.
  - CHECK, en=1, din != expected and din == 0 (restart):
    - restart_pulse=1, locked <= 0, match_run=0.
    - prev2 <= 0; go to SEED1.
    - Not counted as an error.
  - CHECK, en=1, din != expected and din != 0 (error):
    - err_pulse=1, err_sticky=1, err_cnt++ (saturating).
    - locked <= 0, match_run=0.
    - Resync on the received term: prev2 <= prev1, prev1 <= din; stay in CHECK.
- A legitimate 0 (e.g. F12 mod 16 = 0) is a match, never a restart.
- err_pulse and restart_pulse are mutually exclusive.
- rst asserted mid-stream: everything clears immediately. The first sample after release is seed 0.
- Synthesisable, single clock domain. `din` and `en` are assumed synchronous to clk.

Test Plan:
- Reset release, generator stream 0,1,1,2,3,5,8,13,5,2,7,9,0,9,9,2 with en=1 -> zero errors; locked rises on the cycle after the 5th sample (seeds + 3 matches); term_cnt=16, err_cnt=0; `expected` shows 5 after 8,13.
- en gating: stream 0,1,1,2 with en=0 for 15 cycles, then 3,5 -> no state change while en=0; no error on resume; term_cnt=6.
- Corrupt term: 0,1,1,2,4,6,10 -> err_pulse one cycle after the 4 arrives; err_cnt=1, err_sticky=1, locked=0; resync makes 6 (=2+4) and 10 a match; locked returns after LOCK_N further matches.
- Restart: locked stream ...,5,8 then 0,1,1,2 -> restart_pulse one cycle after the 0; err_cnt unchanged; locked re-asserts after 3 matches.
- Saturation with CNT_W=4: 20 accepted terms -> term_cnt holds 15; 20 forced mismatches -> err_cnt holds 15.
- clr and rst mid-stream: clr=1 together with en=1 -> counters 0, state SEED0, sample ignored; rst pulse between clock edges -> outputs 0 immediately, without waiting for an edge.
